uart_tx_framed: RTL

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framed.sv
// ============================================================================
// Module   : uart_tx_framed
// Purpose  : Framed UART transmitter. A frame of DATA_BITS data bits
//            (LSB first), an optional parity bit and STOP_BITS stop bits is
//            sent on tx, preceded by a start bit. Every line bit lasts
//            CLKS_PER_BIT = CLK_HZ/BAUD clock cycles. A transfer made in the
//            final stop-bit cycle starts the next frame with no idle gap.
// Ports    : clk      - sole clock, rising edge
//            rst      - asynchronous active-high reset
//            in_valid - frame request present on in_data
//            in_ready - block accepts in_data this cycle
//            in_data  - payload, DATA_BITS wide
//            brk      - break request (only with UART_TX_BREAK_EN)
//            tx       - serial line, idle high, registered
//            busy     - high whenever the FSM is not idle
// Options  : define UART_TX_BREAK_EN to enable the line-break feature.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_framed #(
    parameter int BAUD      = 115200,
    parameter int CLK_HZ    = 25000000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 brk,
    output logic                 tx,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 1);

    // Elaboration-time parameter legality checks
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_framed: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_framed: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_framed: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_framed: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK = 3'd5
`endif
    } state_t;

    state_t                 r_state,  w_state_nxt;
    logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
    logic [BIT_W-1:0]       r_bit,    w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift,  w_shift_nxt;
    logic                   r_par,    w_par_nxt;
    logic                   r_tx,     w_tx_nxt;
    logic                   w_brk_req;
    logic                   w_last_stop;
    logic                   w_take;

`ifdef UART_TX_BREAK_EN
    assign w_brk_req = brk;
`else
    logic w_unused_brk;
    assign w_unused_brk = brk;
    assign w_brk_req    = 1'b0;
`endif

    // Final cycle of the last stop bit: the only in-frame point that accepts
    // a new request, so consecutive frames abut without an idle bit.
    assign w_last_stop = (r_state == S_STOP) && (r_bit == STOP_LAST) && (r_cnt == CNT_LAST);

    // A pending break request withholds ready in IDLE so brk wins over in_valid.
    assign in_ready = !rst && (((r_state == S_IDLE) && !w_brk_req) || w_last_stop);
    assign w_take   = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE);
    assign tx       = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // tx is registered, so each branch computes the level of the bit that
    // begins at the coming edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                w_tx_nxt  = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (brk) begin
                    w_state_nxt = S_BREAK;
                    w_tx_nxt    = 1'b0;
                end
`endif
            end
            S_START: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_bit == DATA_LAST) begin
                        w_bit_nxt = '0;
                        if (PAR_EN) begin
                            w_state_nxt = S_PAR;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            S_PAR: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b0;
                if (!brk) begin
                    // Starting STOP at its last index yields exactly one
                    // stop-bit time, whatever STOP_BITS is.
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = STOP_LAST;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Accepting a frame overrides the per-state result (IDLE or the final
        // stop-bit cycle).
        if (w_take) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = in_data;
            w_par_nxt   = (^in_data) ^ PAR_ODD;
            w_tx_nxt    = 1'b0;
        end
    end

endmodule

`default_nettype wire
